// File: rtl/key_input_ctrl_if.sv
// Key input interface: scancode stream and enable in, one-cycle key pulses out.
interface key_input_ctrl_if;
  logic [7:0] code;
  logic       code_valid;
  logic       en;
  logic       key_left;
  logic       key_right;
  logic       key_down;
  logic       key_rotate;
  logic       key_drop;

  modport master (
    output code, code_valid, en,
    input  key_left, key_right, key_down, key_rotate, key_drop
  );

  modport slave (
    input  code, code_valid, en,
    output key_left, key_right, key_down, key_rotate, key_drop
  );
endinterface

// File: rtl/key_input_ctrl.sv
// PS/2 scancode to game key pulses, with delayed auto-shift and auto-repeat
// for left/right/down. Optional WASD aliases enabled by defining KEY_WASD_EN.
// Key bit order everywhere: 0=left 1=right 2=down 3=rotate 4=drop.
module key_input_ctrl #(
  parameter int unsigned DAS_CYCLES = 16_000_000,
  parameter int unsigned ARR_CYCLES = 5_000_000,
  parameter int unsigned CNT_W      = 24
) (
  input logic             clk,
  input logic             rst_n,
  key_input_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DasLast = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ArrLast = CNT_W'(ARR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             held_q, held_d;
  logic [4:0]             out_q, out_d;
  logic                   lr_right_q, lr_right_d;  // last left/right press was right
  logic [2:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]             rep_q, rep_d;            // first (DAS) repeat already issued
  logic [4:0]             make_key, brk_key, press, rel;
  logic [2:0]             suppress, rep_pulse;

  function automatic logic [4:0] map_key(input logic [7:0] c, input logic ext);
    logic [4:0] k;
    k = '0;
    if (ext) begin
      case (c)
        8'h6B:   k[0] = 1'b1;
        8'h74:   k[1] = 1'b1;
        8'h72:   k[2] = 1'b1;
        8'h75:   k[3] = 1'b1;
        default: k = '0;
      endcase
    end else begin
      case (c)
        8'h29:   k[4] = 1'b1;
`ifdef KEY_WASD_EN
        8'h1C:   k[0] = 1'b1;
        8'h23:   k[1] = 1'b1;
        8'h1B:   k[2] = 1'b1;
        8'h1D:   k[3] = 1'b1;
`endif
        default: k = '0;
      endcase
    end
    return k;
  endfunction

  // Parser: prefix tracking and make/break decode on each code_valid strobe.
  always_comb begin
    state_d  = state_q;
    make_key = '0;
    brk_key  = '0;
    if (bus.code_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.code == 8'hE0)      state_d = StExt;
          else if (bus.code == 8'hF0) state_d = StBrk;
          else                        make_key = map_key(bus.code, 1'b0);
        end
        StExt: begin
          if (bus.code == 8'hF0) begin
            state_d = StExtBrk;
          end else begin
            make_key = map_key(bus.code, 1'b1);
            state_d  = StIdle;
          end
        end
        StBrk: begin
          brk_key = map_key(bus.code, 1'b0);
          state_d = StIdle;
        end
        StExtBrk: begin
          brk_key = map_key(bus.code, 1'b1);
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Held flags and left/right ownership; typematic makes of held keys are dropped.
  always_comb begin
    press      = make_key & ~held_q;
    rel        = brk_key & held_q;
    held_d     = (held_q | press) & ~rel;
    lr_right_d = lr_right_q;
    if (press[1])      lr_right_d = 1'b1;
    else if (press[0]) lr_right_d = 1'b0;
  end

  // The direction not pressed most recently never repeats.
  assign suppress = {1'b0, ~lr_right_d, lr_right_d};

  // Repeat timers for left/right/down plus registered output pulses.
  always_comb begin
    rep_pulse = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      rep_d[i] = rep_q[i];
      if (press[i] || rel[i] || !bus.en || !held_q[i] || suppress[i]) begin
        cnt_d[i] = '0;
        rep_d[i] = 1'b0;
      end else if (cnt_q[i] == (rep_q[i] ? ArrLast : DasLast)) begin
        cnt_d[i]     = '0;
        rep_d[i]     = 1'b1;
        rep_pulse[i] = 1'b1;
      end
    end
    out_d = bus.en ? (press | {2'b00, rep_pulse}) : '0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      held_q     <= '0;
      out_q      <= '0;
      lr_right_q <= 1'b0;
      cnt_q      <= '0;
      rep_q      <= '0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      out_q      <= out_d;
      lr_right_q <= lr_right_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
    end
  end

  assign bus.key_left   = out_q[0];
  assign bus.key_right  = out_q[1];
  assign bus.key_down   = out_q[2];
  assign bus.key_rotate = out_q[3];
  assign bus.key_drop   = out_q[4];

endmodule
